// File: rtl/dbus_ram_responder.sv
// Data-bus RAM responder: accepts one request at a time, replies LATENCY cycles later
// with the pre-write word, and applies byte-lane writes unless the access is misaligned.
module dbus_ram_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [3:0]  req_strobe,
  input  logic [31:0] req_data,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] resp_data,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         state;
  state_t         state_next;
  logic [3:0]     count;
  logic [AW-1:0]  index_q;
  logic [3:0]     strobe_q;
  logic [31:0]    data_q;
  logic           misaligned_q;
  logic           misaligned;
  logic           accept;
  logic [31:0]    read_word;
  logic [31:0]    mem [DEPTH_WORDS];

  // Address bits above the storage window wrap and are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:AW+2];

  assign accept    = (state == IDLE) && req_valid && !reset;
  assign read_word = mem[index_q];

  always_comb begin
    case (req_size)
      3'd0:    misaligned = 1'b0;
      3'd1:    misaligned = req_addr[0];
      default: misaligned = (req_addr[1:0] != 2'b00);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (count <= 4'd1) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    addr_ok   = 1'b0;
    data_ok   = 1'b0;
    resp_data = 32'h0;
    err       = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: addr_ok = req_valid;
        RESP: begin
          data_ok   = 1'b1;
          resp_data = read_word;
          err       = misaligned_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)               count <= 4'd0;
    else if (accept)         count <= 4'(LATENCY - 1);
    else if (state == WAIT)  count <= count - 4'd1;
  end

  // Only the decoded word index and alignment verdict are kept from the address.
  always_ff @(posedge clk) begin
    if (accept) begin
      index_q      <= req_addr[AW+1:2];
      strobe_q     <= req_strobe;
      data_q       <= req_data;
      misaligned_q <= misaligned;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state == RESP && !misaligned_q) begin
      for (int i = 0; i < 4; i++) begin
        if (strobe_q[i]) mem[index_q][8*i +: 8] <= data_q[8*i +: 8];
      end
    end
  end

endmodule
